// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue_pkg : shared pipeline width, NOP encoding, fetch entry   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] C_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            alloc;
    logic            filled;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue_if : PC-control, instruction-memory and decode signals   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface fetch_queue_if #(
  parameter int XLEN = fetch_queue_pkg::XLEN
) ();

  logic            br_ctrl;
  logic [XLEN-1:0] pc_in;
  logic            pc_stall;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;

  modport master (
    input  pc_in, br_ctrl, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output pc_stall, imem_req, imem_addr, id_valid, id_pc, id_instr
  );

  modport slave (
    output pc_in, br_ctrl, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  pc_stall, imem_req, imem_addr, id_valid, id_pc, id_instr
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue : in-order instruction fetch buffer with flush dropping  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = fetch_queue_pkg::XLEN
) (
  input  wire logic     clk,
  input  wire logic     reset,
  fetch_queue_if.master bus
);

  import fetch_queue_pkg::*;

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] C_DEPTH   = C_CNT_W'(DEPTH);

  logic [C_PTR_W-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [C_CNT_W-1:0] count_q, count_d, drop_cnt_q, drop_cnt_d;
  fetch_entry_t       entries_q [DEPTH];
  fetch_entry_t       entries_d [DEPTH];

  logic               w_issue, w_pop, w_fill;
  logic [C_CNT_W-1:0] w_unfilled;
  fetch_entry_t       w_head;

  assign w_head        = entries_q[head_q];
  assign bus.imem_req  = !reset && (count_q < C_DEPTH) && !bus.br_ctrl;
  assign bus.imem_addr = bus.pc_in;
  assign w_issue       = bus.imem_req && bus.imem_gnt;
  assign bus.pc_stall  = !w_issue;
  assign bus.id_valid  = w_head.alloc && w_head.filled;
  assign bus.id_pc     = XLEN'(w_head.pc);
  assign bus.id_instr  = XLEN'(w_head.instr);
  assign w_pop         = bus.id_valid && bus.id_ready && !bus.br_ctrl;
  assign w_fill        = bus.imem_rvalid && (drop_cnt_q == '0) && !bus.br_ctrl;

  // Requests still owed a response; these become drops on a flush.
  always_comb begin
    w_unfilled = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].alloc && !entries_q[i].filled) begin
        w_unfilled = w_unfilled + C_CNT_ONE;
      end
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.br_ctrl) begin
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      drop_cnt_d = (bus.imem_rvalid && (w_unfilled != '0)) ? w_unfilled - C_CNT_ONE : w_unfilled;
    end else begin
      if (w_issue) tail_d = tail_q + C_PTR_ONE;
      if (w_fill)  fill_d = fill_q + C_PTR_ONE;
      if (w_pop)   head_d = head_q + C_PTR_ONE;
      if (w_issue && !w_pop) begin
        count_d = count_q + C_CNT_ONE;
      end else if (w_pop && !w_issue) begin
        count_d = count_q - C_CNT_ONE;
      end
      if (bus.imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - C_CNT_ONE;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    if (bus.br_ctrl) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i] = '0;
      end
    end else begin
      if (w_issue) begin
        entries_d[tail_q] = '{pc: bus.pc_in, instr: C_NOP, alloc: 1'b1, filled: 1'b0};
      end
      if (w_fill) begin
        entries_d[fill_q].instr  = bus.imem_rdata;
        entries_d[fill_q].filled = 1'b1;
      end
      if (w_pop) begin
        entries_d[head_q].alloc  = 1'b0;
        entries_d[head_q].filled = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  // A response that is neither dropped nor owed to an allocated entry is a memory protocol error.
  a_no_orphan_fill : assert property (@(posedge clk) disable iff (reset)
    (bus.imem_rvalid && (drop_cnt_q == '0)) |-> (entries_q[fill_q].alloc && !entries_q[fill_q].filled));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_queue : directed self-checking bench for fetch_queue        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fetch_queue;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  fetch_queue_if #(.XLEN(32)) bus ();

  fetch_queue #(.DEPTH(2), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pc_in       = '0;
    bus.br_ctrl     = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.id_ready    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset        = 1'b1;
    bus.imem_gnt = 1'b1;
    #2;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %0b want 0", bus.imem_req); end
    checks++; if (bus.pc_stall !== 1'b1) begin errors++; $display("FAIL reset_pc_stall: got %0b want 1", bus.pc_stall); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %0b want 0", bus.id_valid); end
    checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", bus.id_pc); end
    checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_instr: got %h want 0", bus.id_instr); end
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_imem_req: got %0b want 1", bus.imem_req); end
    checks++; if (bus.pc_stall !== 1'b1) begin errors++; $display("FAIL post_reset_stall_no_gnt: got %0b want 1", bus.pc_stall); end
  endtask

  task automatic test_single_fetch();
    tick();
    bus.pc_in = 32'h0; bus.imem_gnt = 1'b1;
    #1;
    checks++; if (bus.pc_stall !== 1'b0) begin errors++; $display("FAIL single_issue_stall: got %0b want 0", bus.pc_stall); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL single_imem_addr: got %h want 0", bus.imem_addr); end
    tick();
    bus.pc_in = 32'h4; bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0050_0093;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %0b want 0", bus.id_valid); end
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL single_id_valid: got %0b want 1", bus.id_valid); end
    checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL single_id_pc: got %h want 0", bus.id_pc); end
    checks++; if (bus.id_instr !== 32'h0050_0093) begin errors++; $display("FAIL single_id_instr: got %h want 00500093", bus.id_instr); end
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL single_after_pop: got %0b want 0", bus.id_valid); end
  endtask

  task automatic test_backpressure();
    tick();
    idle();
    bus.pc_in = 32'h10; bus.imem_gnt = 1'b1;
    tick();
    bus.pc_in = 32'h14; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_0001;
    tick();
    bus.pc_in = 32'h18; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_0002;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req: got %0b want 0", bus.imem_req); end
    checks++; if (bus.pc_stall !== 1'b1) begin errors++; $display("FAIL bp_full_stall: got %0b want 1", bus.pc_stall); end
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    checks++; if (dut.count_q !== 2'd2) begin errors++; $display("FAIL bp_count: got %0d want 2", dut.count_q); end
    checks++; if (bus.pc_stall !== 1'b1) begin errors++; $display("FAIL bp_held_stall: got %0b want 1", bus.pc_stall); end
    checks++; if (bus.id_pc !== 32'h10 || bus.id_instr !== 32'h1111_0001) begin errors++; $display("FAIL bp_head: got %h/%h want 10/11110001", bus.id_pc, bus.id_instr); end
    bus.id_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_req: got %0b want 0", bus.imem_req); end
    tick();
    bus.id_ready = 1'b0;
    #1;
    checks++; if (bus.pc_stall !== 1'b0) begin errors++; $display("FAIL bp_reissue_stall: got %0b want 0", bus.pc_stall); end
    checks++; if (bus.id_pc !== 32'h14 || bus.id_instr !== 32'h1111_0002) begin errors++; $display("FAIL bp_second: got %h/%h want 14/11110002", bus.id_pc, bus.id_instr); end
    tick();
    bus.imem_gnt = 1'b0; bus.pc_in = 32'h1c;
    #1;
    checks++; if (dut.count_q !== 2'd2) begin errors++; $display("FAIL bp_count_after: got %0d want 2", dut.count_q); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_0003; bus.id_ready = 1'b1;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h18 || bus.id_instr !== 32'h1111_0003) begin errors++; $display("FAIL bp_third: got %0b %h/%h want 1 18/11110003", bus.id_valid, bus.id_pc, bus.id_instr); end
    tick();
    bus.id_ready = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b want 0", bus.id_valid); end
  endtask

  task automatic test_flush_inflight();
    tick();
    idle();
    bus.pc_in = 32'h40; bus.imem_gnt = 1'b1;
    tick();
    bus.pc_in = 32'h44;
    tick();
    bus.imem_gnt = 1'b0; bus.br_ctrl = 1'b1; bus.pc_in = 32'h48;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL flush_req: got %0b want 0", bus.imem_req); end
    tick();
    bus.br_ctrl = 1'b0; bus.pc_in = 32'h100; bus.imem_gnt = 1'b1;
    #1;
    checks++; if (dut.drop_cnt_q !== 2'd2) begin errors++; $display("FAIL flush_drop_cnt: got %0d want 2", dut.drop_cnt_q); end
    tick();
    bus.imem_gnt = 1'b0; bus.pc_in = 32'h104;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0000;
    tick();
    bus.imem_rdata = 32'hBAD0_0001;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_stale1: got %0b want 0", bus.id_valid); end
    tick();
    bus.imem_rdata = 32'h0100_0113;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_stale2: got %0b want 0", bus.id_valid); end
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100 || bus.id_instr !== 32'h0100_0113) begin errors++; $display("FAIL flush_new: got %0b %h/%h want 1 100/01000113", bus.id_valid, bus.id_pc, bus.id_instr); end
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
  endtask

  task automatic test_flush_with_rvalid();
    tick();
    idle();
    bus.pc_in = 32'h200; bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0; bus.br_ctrl = 1'b1;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_0200;
    tick();
    idle();
    #1;
    checks++; if (dut.drop_cnt_q !== 2'd0) begin errors++; $display("FAIL flushrv_drop_cnt: got %0d want 0", dut.drop_cnt_q); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flushrv_id_valid: got %0b want 0", bus.id_valid); end
    bus.pc_in = 32'h300; bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0; bus.pc_in = 32'h304;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0300_0013;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h300 || bus.id_instr !== 32'h0300_0013) begin errors++; $display("FAIL flushrv_next: got %0b %h/%h want 1 300/03000013", bus.id_valid, bus.id_pc, bus.id_instr); end
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
  endtask

  task automatic test_back_to_back_wrap();
    logic [31:0] next_pc;
    logic [31:0] pend_pc;
    logic [31:0] exp_pc;
    logic        pend;
    int          issued;
    int          delivered;
    int          cycles;
    next_pc = 32'h0; pend = 1'b0; pend_pc = '0;
    issued = 0; delivered = 0; cycles = 0;
    tick();
    idle();
    while (delivered < 10 && cycles < 200) begin
      bus.imem_rvalid = pend;
      bus.imem_rdata  = 32'hA000_0000 | pend_pc;
      bus.pc_in       = next_pc;
      bus.imem_gnt    = (issued < 10);
      bus.id_ready    = 1'b1;
      #1;
      if (bus.id_valid) begin
        exp_pc = 32'(delivered) * 32'd4;
        checks++; if (bus.id_pc !== exp_pc) begin errors++; $display("FAIL wrap_pc[%0d]: got %h want %h", delivered, bus.id_pc, exp_pc); end
        checks++; if (bus.id_instr !== (32'hA000_0000 | exp_pc)) begin errors++; $display("FAIL wrap_instr[%0d]: got %h want %h", delivered, bus.id_instr, 32'hA000_0000 | exp_pc); end
        delivered++;
      end
      pend = bus.imem_req && bus.imem_gnt;
      if (pend) begin
        pend_pc = bus.pc_in;
        next_pc = next_pc + 32'd4;
        issued++;
      end
      tick();
      cycles++;
    end
    idle();
    checks++; if (delivered != 10) begin errors++; $display("FAIL wrap_delivered: got %0d want 10", delivered); end
  endtask

  task automatic test_async_reset();
    tick();
    idle();
    bus.pc_in = 32'h500; bus.imem_gnt = 1'b1;
    tick();
    bus.pc_in = 32'h504; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0500_0013;
    tick();
    bus.pc_in = 32'h508; bus.imem_rvalid = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL areset_pre: got valid=%0b req=%0b want 1/0", bus.id_valid, bus.imem_req); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL areset_id_valid: got %0b want 0", bus.id_valid); end
    checks++; if (bus.pc_stall !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL areset_stall: got stall=%0b req=%0b want 1/0", bus.pc_stall, bus.imem_req); end
    checks++; if (dut.count_q !== 2'd0 || bus.id_pc !== 32'h0) begin errors++; $display("FAIL areset_state: got count=%0d pc=%h want 0/0", dut.count_q, bus.id_pc); end
    tick();
    reset = 1'b0;
    idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_flush_inflight();
    test_flush_with_rvalid();
    test_back_to_back_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 2, meaning number of queue entries; legal values are powers of two, 2..8.
REQ-002 Parameter XLEN, default 32, meaning width of the PC and the instruction.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc_in  input  XLEN  current fetch PC from PC control.
REQ-006 br_ctrl  input  1  redirect/flush pulse, the same signal that loads the branch destination into PC control.
REQ-007 pc_stall  output  1  hold request to PC control; 1 = PC shall not advance this cycle.
REQ-008 imem_req  output  1  instruction memory request valid.
REQ-009 imem_addr  output  XLEN  instruction memory request address.
REQ-010 imem_gnt  input  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  response valid; responses return in order, latency of at least 1 cycle.
REQ-012 imem_rdata  input  XLEN  response instruction word.
REQ-013 id_valid  output  1  head entry holds a fetched instruction.
REQ-014 id_ready  input  1  decode accepts the head entry this cycle.
REQ-015 id_pc  output  XLEN  PC of the head entry.
REQ-016 id_instr  output  XLEN  instruction of the head entry.

Function
REQ-017 Each entry SHALL hold alloc, filled, pc and instr fields; the queue is a circular buffer with head, tail and fill pointers, each log2(DEPTH) bits wide, wrapping modulo DEPTH.
REQ-018 imem_req SHALL equal (count < DEPTH) && !br_ctrl, where count is the number of allocated entries; imem_addr SHALL equal pc_in combinationally.
REQ-019 On an issue (imem_req && imem_gnt), the entry at tail SHALL be allocated with pc = pc_in and filled = 0, and tail SHALL advance.
REQ-020 pc_stall SHALL equal !(imem_req && imem_gnt), so the PC advances exactly once per accepted request.
REQ-021 On imem_rvalid with drop_cnt == 0, imem_rdata SHALL be written to the entry at the fill pointer, filled SHALL be set, and the fill pointer SHALL advance.
REQ-022 id_valid SHALL equal alloc && filled of the head entry, which gives a minimum latency of 1 cycle from rvalid to id_valid; there is no bypass.
REQ-023 id_pc and id_instr SHALL reflect the head entry whenever id_valid = 1 and are don't-care otherwise.
REQ-024 On id_valid && id_ready, the head entry SHALL be freed and head SHALL advance.
REQ-025 Pop and issue in the same cycle SHALL both take effect; count is unchanged.
REQ-026 A full queue (count == DEPTH) SHALL hold imem_req = 0 and pc_stall = 1 until a pop occurs; the issue may happen in the same cycle as that pop only if count < DEPTH was true at the start of the cycle (issue is decided from the registered count).
REQ-027 On br_ctrl, all entries SHALL be cleared and head = tail = fill = 0, and no issue or pop SHALL take effect in that cycle.
REQ-028 On br_ctrl, drop_cnt SHALL be loaded with (alloc-unfilled entries) minus (1 if imem_rvalid that cycle).
REQ-029 While drop_cnt > 0, each imem_rvalid SHALL decrement drop_cnt and the response data SHALL be discarded.
REQ-030 Fills SHALL never exceed allocations; imem_rvalid arriving with no outstanding request is an assertion failure.
REQ-031 The count and drop_cnt registers SHALL be log2(DEPTH)+1 bits wide and SHALL never overflow.

Reset
REQ-032 Asserting reset SHALL immediately clear all alloc/filled bits, all pointers, count and drop_cnt, independent of clk.
REQ-033 During reset: imem_req = 0, pc_stall = 1, id_valid = 0; id_pc = 0 and id_instr = 0.
REQ-034 Reset asserted mid-operation SHALL abandon any in-flight responses; the memory is reset by the same signal, so no drop accounting is required.

Structure
REQ-035 A shared pipeline package SHALL hold XLEN, the NOP encoding (0x00000013) and the fetch-entry struct (pc, instr, alloc, filled).
REQ-036 The block SHALL be a single module with no sub-modules.
REQ-037 Pointer and count logic SHALL be kept separate from the entry storage.

Verification
REQ-038 Single fetch: reset release, pc_in=0x0, gnt=1, rvalid 1 cycle later with 0x00500093 -> id_valid=1 with id_pc=0x0, id_instr=0x00500093; pc_stall=0 on the issue cycle.
REQ-039 Backpressure: id_ready=0, gnt=1, two responses returned -> count=2, imem_req=0 and pc_stall=1 held; one id_ready pulse -> one pop and one new issue.
REQ-040 Flush with in-flight: two requests issued, br_ctrl before any rvalid -> drop_cnt=2, next two rvalids discarded, id_valid stays 0; third response (to the new PC 0x100) is delivered with id_pc=0x100.
REQ-041 Flush coincident with rvalid: one request outstanding, br_ctrl and rvalid in the same cycle -> drop_cnt=0, queue empty, no spurious id_valid.
REQ-042 Wrap-around: 10 back-to-back fetches at 0x0..0x24 with id_ready=1 -> delivered in order with correct PCs across pointer wrap.
REQ-043 Async reset: reset asserted mid-cycle with count=2 -> id_valid=0 and pc_stall=1 before the next clk edge.
